// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer: FSM state encoding, the
// release order of clock domains and a width helper.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    StPllRst,
    StWaitLock,
    StStable,
    StRelease,
    StRun
  } seq_state_e;

  // Bit positions in domain_rst_n; lower indices are released first.
  localparam int unsigned DomPixel   = 0;
  localparam int unsigned DomPixel90 = 1;
  localparam int unsigned DomCpu     = 2;
  localparam int unsigned DomVram    = 3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser with asynchronous active-low clear, used to bring the PLL lock
// indication into the reference clock domain.
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a stable lock with timeout and
// retry, then releases the per-domain resets one at a time. Tears down on lock loss/relock.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS  = DomVram + 1,
  parameter int unsigned PLL_RST_CYC  = 16,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 262144,
  parameter int unsigned STAGE_GAP    = 64,
  parameter int unsigned MAX_RETRY    = 7
) (
  input  logic                           clk_74a,
  input  logic                           reset_n,
  input  logic                           pll_locked,
  input  logic                           relock_req,
  output logic                           pll_rst,
  output logic [NUM_DOMAINS-1:0]         domain_rst_n,
  output logic                           seq_ready,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_count,
  output logic                           lock_fail
);

  // +1 so the counter can hold the largest terminal value itself.
  localparam int unsigned TimerW  = $clog2(max3(PLL_RST_CYC, LOCK_TIMEOUT, STAGE_GAP) + 1);
  localparam int unsigned StableW = $clog2(LOCK_STABLE + 1);
  localparam int unsigned IdxW    = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int unsigned RCW     = $clog2(MAX_RETRY + 1);

  seq_state_e             state_q, state_d;
  logic [TimerW-1:0]      timer_q, timer_d;
  logic [StableW-1:0]     stable_q, stable_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   pll_rst_q, pll_rst_d;
  logic [NUM_DOMAINS-1:0] domain_q, domain_d;
  logic                   seq_ready_q, seq_ready_d;
  logic [RCW-1:0]         retry_q, retry_d;
  logic                   lock_fail_q, lock_fail_d;
  logic                   lock_s;
  logic                   timed_out;

  sync2 u_lock_sync (
    .clk_i  (clk_74a),
    .rst_ni (reset_n),
    .d_i    (pll_locked),
    .q_o    (lock_s)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    stable_d  = stable_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    domain_d  = '0;
    timed_out = (timer_q == TimerW'(LOCK_TIMEOUT - 1));

    if (relock_req) begin
      state_d = StPllRst;
      timer_d = '0;
    end else begin
      unique case (state_q)
        StPllRst: begin
          if (timer_q == TimerW'(PLL_RST_CYC - 1)) begin
            state_d = StWaitLock;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        // The timeout keeps running through STABLE so a glitchy lock cannot stall retries.
        StWaitLock, StStable: begin
          timer_d = timer_q + 1'b1;
          if (state_q == StStable && lock_s && stable_q == StableW'(LOCK_STABLE - 1)) begin
            state_d = StRelease;
            timer_d = '0;
            idx_d   = IdxW'(DomPixel);
          end else if (timed_out) begin
            state_d = StPllRst;
            timer_d = '0;
            if (retry_q != RCW'(MAX_RETRY)) retry_d = retry_q + 1'b1;
          end else if (!lock_s) begin
            state_d = StWaitLock;
          end else if (state_q == StWaitLock) begin
            state_d  = StStable;
            stable_d = '0;
          end else begin
            stable_d = stable_q + 1'b1;
          end
        end
        StRelease: begin
          if (!lock_s) begin
            state_d = StPllRst;
            timer_d = '0;
          end else begin
            domain_d = domain_q | (NUM_DOMAINS'(1) << idx_q);
            if (idx_q == IdxW'(NUM_DOMAINS - 1)) begin
              // Last bit rises on the first cycle of this index; RUN follows one cycle later.
              if (timer_q != '0) state_d = StRun;
              else               timer_d = timer_q + 1'b1;
            end else if (timer_q == TimerW'(STAGE_GAP - 1)) begin
              timer_d = '0;
              idx_d   = idx_q + 1'b1;
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
        end
        StRun: begin
          if (!lock_s) begin
            state_d = StPllRst;
            timer_d = '0;
          end else begin
            domain_d = '1;
          end
        end
        default: begin
          state_d = StPllRst;
          timer_d = '0;
        end
      endcase
    end

    lock_fail_d = lock_fail_q | (retry_d == RCW'(MAX_RETRY));
    pll_rst_d   = (state_d == StPllRst);
    seq_ready_d = (state_d == StRun);
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StPllRst;
      timer_q     <= '0;
      stable_q    <= '0;
      idx_q       <= '0;
      pll_rst_q   <= 1'b1;
      domain_q    <= '0;
      seq_ready_q <= 1'b0;
      retry_q     <= '0;
      lock_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      stable_q    <= stable_d;
      idx_q       <= idx_d;
      pll_rst_q   <= pll_rst_d;
      domain_q    <= domain_d;
      seq_ready_q <= seq_ready_d;
      retry_q     <= retry_d;
      lock_fail_q <= lock_fail_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign domain_rst_n = domain_q;
  assign seq_ready    = seq_ready_q;
  assign retry_count  = retry_q;
  assign lock_fail    = lock_fail_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with small timing parameters; expected
// events are queued when stimulus is applied and popped as the DUT produces them.
module tb_pll_reset_sequencer;

  localparam int unsigned NumDom   = 4;
  localparam int unsigned RstCyc   = 4;
  localparam int unsigned StableC  = 8;
  localparam int unsigned Timeout  = 100;
  localparam int unsigned Gap      = 4;
  localparam int unsigned MaxRetry = 2;

  typedef struct packed {
    int   cyc;
    int   retry;
    logic fail;
  } ev_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              pll_locked;
  logic              relock_req;
  logic              pll_rst;
  logic [NumDom-1:0] domain_rst_n;
  logic              seq_ready;
  logic [1:0]        retry_count;
  logic              lock_fail;

  int n_tests = 0;
  int n_fail  = 0;
  int   exp_q[$];
  ev_t  ev_q[$];

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .NUM_DOMAINS  (NumDom),
    .PLL_RST_CYC  (RstCyc),
    .LOCK_STABLE  (StableC),
    .LOCK_TIMEOUT (Timeout),
    .STAGE_GAP    (Gap),
    .MAX_RETRY    (MaxRetry)
  ) dut (
    .clk_74a      (clk),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .relock_req   (relock_req),
    .pll_rst      (pll_rst),
    .domain_rst_n (domain_rst_n),
    .seq_ready    (seq_ready),
    .retry_count  (retry_count),
    .lock_fail    (lock_fail)
  );

  task automatic wait_ready(input int max_cyc, output int cyc_out);
    cyc_out = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (seq_ready === 1'b1) begin
        cyc_out = i;
        break;
      end
    end
  endtask

  // Edges until pll_rst is seen low, starting while it is high.
  task automatic count_pll_rst(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pll_rst === 1'b1 && n < 50);
  endtask

  task automatic test_reset();
    reset_n = 1'b1; pll_locked = 1'b0; relock_req = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    n_tests++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pll_rst got %b want 1", pll_rst); end
    n_tests++; if (domain_rst_n !== '0) begin n_fail++; $display("FAIL reset_domain got %h want 0", domain_rst_n); end
    n_tests++; if (seq_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", seq_ready); end
    n_tests++; if (retry_count !== 2'd0) begin n_fail++; $display("FAIL reset_retry got %0d want 0", retry_count); end
    n_tests++; if (lock_fail !== 1'b0) begin n_fail++; $display("FAIL reset_lock_fail got %b want 0", lock_fail); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_bringup();
    int fall_cyc, last_rise, ready_cyc, eb;
    logic [NumDom-1:0] prev, rose, exp_mask;
    fall_cyc = -1; last_rise = -1; ready_cyc = -1; prev = '0;
    for (int b = 0; b < NumDom; b++) exp_q.push_back(b);
    reset_n = 1'b1;
    for (int cyc = 1; cyc <= 400 && ready_cyc < 0; cyc++) begin
      if (cyc == 10) pll_locked = 1'b1;
      @(negedge clk);
      if (fall_cyc < 0 && pll_rst === 1'b0) fall_cyc = cyc;
      rose = domain_rst_n & ~prev;
      prev = domain_rst_n;
      if (rose != '0) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bringup_order got rise %b want none", rose);
        end else begin
          eb = exp_q.pop_front();
          exp_mask = NumDom'(1) << eb;
          if (rose !== exp_mask) begin
            n_fail++; $display("FAIL bringup_order got rise %b want %b", rose, exp_mask);
          end
        end
        if (last_rise >= 0) begin
          n_tests++;
          if (cyc - last_rise != Gap) begin
            n_fail++; $display("FAIL bringup_gap got %0d want %0d", cyc - last_rise, Gap);
          end
        end
        last_rise = cyc;
      end
      if (seq_ready === 1'b1) ready_cyc = cyc;
    end
    n_tests++; if (fall_cyc != RstCyc) begin n_fail++; $display("FAIL bringup_pll_rst_len got %0d want %0d", fall_cyc, RstCyc); end
    n_tests++; if (ready_cyc < 0 || ready_cyc - last_rise != 1) begin
      n_fail++; $display("FAIL bringup_ready_delay got %0d want 1", ready_cyc - last_rise);
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bringup_bits_left got %0d want 0", exp_q.size()); end
    n_tests++; if (retry_count !== 2'd0) begin n_fail++; $display("FAIL bringup_retry got %0d want 0", retry_count); end
    exp_q.delete();
  endtask

  task automatic test_lock_loss();
    logic [1:0] r0;
    int rc;
    r0 = retry_count;
    pll_locked = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (seq_ready !== 1'b1) begin n_fail++; $display("FAIL loss_sync_hold got %b want 1", seq_ready); end
    @(negedge clk);
    n_tests++; if ({pll_rst, seq_ready, domain_rst_n} !== {1'b1, 1'b0, 4'h0}) begin
      n_fail++; $display("FAIL loss_teardown got %b want 1_0_0000", {pll_rst, seq_ready, domain_rst_n});
    end
    n_tests++; if (retry_count !== r0) begin n_fail++; $display("FAIL loss_retry got %0d want %0d", retry_count, r0); end
    pll_locked = 1'b1;
    wait_ready(400, rc);
    n_tests++; if (rc < 0 || domain_rst_n !== 4'hf) begin
      n_fail++; $display("FAIL loss_resequence got ready=%b dom=%h want 1/f", seq_ready, domain_rst_n);
    end
  endtask

  task automatic test_relock();
    logic [1:0] r0;
    int n;
    bit found;
    relock_req = 1'b1;
    @(negedge clk);
    relock_req = 1'b0;
    n_tests++; if ({pll_rst, seq_ready, domain_rst_n} !== {1'b1, 1'b0, 4'h0}) begin
      n_fail++; $display("FAIL relock_run got %b want 1_0_0000", {pll_rst, seq_ready, domain_rst_n});
    end
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (domain_rst_n[1] === 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_tests++; if (!found || domain_rst_n !== 4'b0011) begin
      n_fail++; $display("FAIL relock_partial got %b want 0011", domain_rst_n);
    end
    relock_req = 1'b1;
    pll_locked = 1'b0;
    @(negedge clk);
    relock_req = 1'b0;
    n_tests++; if ({pll_rst, domain_rst_n} !== {1'b1, 4'h0}) begin
      n_fail++; $display("FAIL relock_release got %b want 1_0000", {pll_rst, domain_rst_n});
    end
    count_pll_rst(n);
    n_tests++; if (n != RstCyc) begin n_fail++; $display("FAIL relock_pll_rst_len got %0d want %0d", n, RstCyc); end
    // Now one edge into WAIT_LOCK; the timeout edge is Timeout edges away.
    r0 = retry_count;
    repeat (Timeout - 1) @(negedge clk);
    relock_req = 1'b1;
    @(negedge clk);
    relock_req = 1'b0;
    n_tests++; if (retry_count !== r0) begin
      n_fail++; $display("FAIL relock_vs_timeout_retry got %0d want %0d", retry_count, r0);
    end
    n_tests++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL relock_vs_timeout_rst got %b want 1", pll_rst); end
  endtask

  task automatic test_glitchy_lock();
    int n, rise_cyc;
    bit dom_ok;
    ev_t ev;
    count_pll_rst(n);
    n_tests++; if (n != RstCyc) begin n_fail++; $display("FAIL glitch_pll_rst_len got %0d want %0d", n, RstCyc); end
    ev_q.push_back('{Timeout, int'(retry_count) + 1, 1'b0});
    dom_ok = 1'b1; rise_cyc = -1;
    for (int cyc = 1; cyc <= 150 && rise_cyc < 0; cyc++) begin
      pll_locked = (((cyc - 1) / 5) % 2 == 0);
      @(negedge clk);
      if (domain_rst_n !== '0) dom_ok = 1'b0;
      if (pll_rst === 1'b1) rise_cyc = cyc;
    end
    n_tests++; if (!dom_ok) begin n_fail++; $display("FAIL glitch_domain got nonzero want 0"); end
    ev = ev_q.pop_front();
    n_tests++; if (rise_cyc != ev.cyc) begin n_fail++; $display("FAIL glitch_timeout_cyc got %0d want %0d", rise_cyc, ev.cyc); end
    n_tests++; if (int'(retry_count) != ev.retry) begin
      n_fail++; $display("FAIL glitch_retry got %0d want %0d", retry_count, ev.retry);
    end
  endtask

  task automatic test_retry();
    logic prev_rst;
    int rc;
    ev_t ev;
    reset_n = 1'b0; pll_locked = 1'b0; relock_req = 1'b0;
    repeat (2) @(negedge clk);
    ev_q.push_back('{RstCyc + Timeout, 1, 1'b0});
    ev_q.push_back('{2 * (RstCyc + Timeout), 2, 1'b1});
    ev_q.push_back('{3 * (RstCyc + Timeout), 2, 1'b1});
    reset_n = 1'b1;
    prev_rst = 1'b1;
    for (int cyc = 1; cyc <= 320; cyc++) begin
      @(negedge clk);
      if (pll_rst === 1'b1 && prev_rst === 1'b0) begin
        n_tests++;
        if (ev_q.size() == 0) begin
          n_fail++; $display("FAIL retry_extra_pulse got cyc %0d want none", cyc);
        end else begin
          ev = ev_q.pop_front();
          if (cyc != ev.cyc) begin n_fail++; $display("FAIL retry_pulse_cyc got %0d want %0d", cyc, ev.cyc); end
          n_tests++;
          if (int'(retry_count) != ev.retry) begin
            n_fail++; $display("FAIL retry_count got %0d want %0d", retry_count, ev.retry);
          end
          n_tests++;
          if (lock_fail !== ev.fail) begin n_fail++; $display("FAIL retry_lock_fail got %b want %b", lock_fail, ev.fail); end
        end
      end
      prev_rst = pll_rst;
    end
    n_tests++; if (ev_q.size() != 0) begin n_fail++; $display("FAIL retry_missing got %0d left want 0", ev_q.size()); end
    ev_q.delete();
    pll_locked = 1'b1;
    wait_ready(600, rc);
    n_tests++; if (rc < 0) begin n_fail++; $display("FAIL retry_late_lock got ready=%b want 1", seq_ready); end
    n_tests++; if ({lock_fail, retry_count} !== {1'b1, 2'd2}) begin
      n_fail++; $display("FAIL retry_sticky got %b want 110", {lock_fail, retry_count});
    end
  endtask

  task automatic test_async_reset();
    int n, rc;
    relock_req = 1'b1; pll_locked = 1'b0;
    @(negedge clk);
    relock_req = 1'b0;
    count_pll_rst(n);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_tests++; if ({pll_rst, domain_rst_n, retry_count, lock_fail} !== {1'b1, 4'h0, 2'd0, 1'b0}) begin
      n_fail++; $display("FAIL areset_wait got %b want 1_0000_00_0", {pll_rst, domain_rst_n, retry_count, lock_fail});
    end
    @(negedge clk);
    reset_n = 1'b1; pll_locked = 1'b1;
    wait_ready(400, rc);
    n_tests++; if (rc < 0 || domain_rst_n !== 4'hf) begin
      n_fail++; $display("FAIL areset_restart1 got ready=%b dom=%h want 1/f", seq_ready, domain_rst_n);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++; if ({pll_rst, seq_ready, domain_rst_n} !== {1'b1, 1'b0, 4'h0}) begin
      n_fail++; $display("FAIL areset_run got %b want 1_0_0000", {pll_rst, seq_ready, domain_rst_n});
    end
    @(negedge clk);
    reset_n = 1'b1;
    count_pll_rst(n);
    n_tests++; if (n != RstCyc) begin n_fail++; $display("FAIL areset_pll_rst_len got %0d want %0d", n, RstCyc); end
    wait_ready(400, rc);
    n_tests++; if (rc < 0) begin n_fail++; $display("FAIL areset_restart2 got ready=%b want 1", seq_ready); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_lock_loss();
    test_relock();
    test_glitchy_lock();
    test_retry();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
